// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding, frame width and baud divisor helper for the UART transmitter
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
  localparam int UART_DATA_BITS = 8;
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction
endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: wrapping bit-period counter with clear and terminal-count flag
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic in_clk,
  input  logic in_rst_n,
  input  logic in_clr,
  output logic out_tc
);
  localparam int W = $clog2(CLKS_PER_BIT);
  logic [W-1:0] cnt;
  assign out_tc = cnt == W'(CLKS_PER_BIT - 1);
  // count 0..CLKS_PER_BIT-1 and wrap; held at zero while cleared
  always_ff @(posedge in_clk) begin
    if (!in_rst_n) cnt <= '0;
    else cnt <= (in_clr || out_tc) ? '0 : cnt + W'(1);
  end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter, LSB first, one frame per accepted in_en strobe
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = clks_per_bit(100_000_000, 115_200)
) (
  input  logic       in_clk,
  input  logic       in_rst_n,
  input  logic       in_en,
  input  logic [7:0] in_data,
  output logic       out_tx,
  output logic       out_busy,
  output logic       out_done
);
  uart_state_t               state;
  logic [UART_DATA_BITS-1:0] shreg;
  logic [2:0]                idx;
  logic                      tc;
  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .in_clk  (in_clk),
    .in_rst_n(in_rst_n),
    .in_clr  (state == IDLE),
    .out_tc  (tc)
  );
  // frame sequencer; every output is registered so the line changes only on bit boundaries
  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      idx      <= '0;
      out_tx   <= 1'b1;
      out_busy <= 1'b0;
      out_done <= 1'b0;
    end else begin
      out_done <= 1'b0;
      case (state)
        IDLE: begin
          out_tx <= 1'b1;
          if (in_en) begin
            shreg    <= in_data;
            out_busy <= 1'b1;
            out_tx   <= 1'b0;
            state    <= START;
          end
        end
        START: if (tc) begin
          idx    <= '0;
          out_tx <= shreg[0];
          state  <= DATA;
        end
        DATA: if (tc) begin
          if (idx == 3'(UART_DATA_BITS - 1)) begin
            out_tx <= 1'b1;
            state  <= STOP;
          end else begin
            idx    <= idx + 3'd1;
            out_tx <= shreg[idx + 3'd1];
          end
        end
        STOP: if (tc) begin
          out_busy <= 1'b0;
          out_done <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule
